// File: rtl/imem_axil_resp.sv
// rtl/imem_axil_resp.sv - AXI4-Lite word-addressed SRAM responder with fixed access latency.
// Serves one read or write at a time; error responses for misaligned or out-of-range addresses.
module imem_axil_resp #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN   = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RWAIT = 3'd1;
  localparam logic [2:0] S_RRESP = 3'd2;
  localparam logic [2:0] S_WWAIT = 3'd3;
  localparam logic [2:0] S_BRESP = 3'd4;

  logic [31:0] mem [DEPTH];

  logic [2:0]            state;
  logic [3:0]            cnt;
  logic [1:0]            resp_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic                  ar_hs;
  logic                  aw_hs;
  logic [31:0]           req_addr;
  logic [31:0]           req_off;
  logic [1:0]            req_resp;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  mem_we;

  assign arready = (state == S_IDLE) & ~rst;
  assign awready = (state == S_IDLE) & ~arvalid & awvalid & wvalid & ~rst;
  assign wready  = awready;

  assign ar_hs = arready & arvalid;
  assign aw_hs = awready;

  // Reads win arbitration, so the decoded address follows the read when both are offered.
  assign req_addr = ar_hs ? araddr : awaddr;
  assign req_off  = req_addr - BASE;
  assign req_idx  = req_off[DEPTH_LOG2+1:2];

  always_comb begin
    req_resp = RESP_OKAY;
    if ({1'b0, req_off} >= SPAN) begin
      req_resp = RESP_DECERR;
    end else if (req_addr[1:0] != 2'b00) begin
      req_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      resp_q  <= RESP_OKAY;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rvalid  <= 1'b0;
      bvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      bresp   <= RESP_OKAY;
    end else begin
      case (state)
        S_IDLE: begin
          if (ar_hs) begin
            state  <= S_RWAIT;
            cnt    <= LAT_M1;
            resp_q <= req_resp;
            idx_q  <= req_idx;
          end else if (aw_hs) begin
            state   <= S_WWAIT;
            cnt     <= LAT_M1;
            resp_q  <= req_resp;
            idx_q   <= req_idx;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
          end
        end
        S_RWAIT: begin
          if (cnt == 4'd0) begin
            state  <= S_RRESP;
            rvalid <= 1'b1;
            rresp  <= resp_q;
            rdata  <= (resp_q == RESP_OKAY) ? mem[idx_q] : 32'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RRESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_WWAIT: begin
          if (cnt == 4'd0) begin
            state  <= S_BRESP;
            bvalid <= 1'b1;
            bresp  <= resp_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_BRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Commit coincides with the WWAIT->BRESP edge; a reset before then discards the write.
  assign mem_we = (state == S_WWAIT) && (cnt == 4'd0) && (resp_q == RESP_OKAY) && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
